// File: rtl/count_sequencer.sv
// Job-based modulo counter: counts up or down between 0 and a latched terminal value for a latched number of wraps.
// All outputs are registered; wrap, done and abort are single-cycle pulses aligned with the state they describe.
module count_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       up_dn,
    input  logic [2:0] mod_val,
    input  logic [3:0] passes,
    output logic [2:0] q,
    output logic [3:0] pass_cnt,
    output logic       busy,
    output logic       wrap,
    output logic       done,
    output logic       abort,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_HOLD = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t     state_q;
    logic [2:0] q_q;
    logic [3:0] pass_cnt_q;
    logic       busy_q;
    logic       wrap_q;
    logic       done_q;
    logic       abort_q;

    logic       up_lat_q;
    logic [2:0] mod_lat_q;
    logic [3:0] pass_lat_q;

    logic [2:0] q_step_d;
    logic [3:0] pass_inc_d;
    logic       term_d;
    logic       last_d;

    // Candidate result of one count step from the current value.
    always_comb begin
        term_d     = up_lat_q ? (q_q == mod_lat_q) : (q_q == 3'd0);
        pass_inc_d = pass_cnt_q + 4'd1;
        last_d     = term_d && (pass_inc_d == pass_lat_q);
        if (term_d) begin
            q_step_d = up_lat_q ? 3'd0 : mod_lat_q;
        end else begin
            q_step_d = up_lat_q ? (q_q + 3'd1) : (q_q - 3'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            q_q        <= 3'd0;
            pass_cnt_q <= 4'd0;
            busy_q     <= 1'b0;
            wrap_q     <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            up_lat_q   <= 1'b0;
            mod_lat_q  <= 3'd0;
            pass_lat_q <= 4'd0;
        end else begin
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        up_lat_q   <= up_dn;
                        mod_lat_q  <= mod_val;
                        pass_lat_q <= passes;
                        state_q    <= S_LOAD;
                        busy_q     <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (stop) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        abort_q <= 1'b1;
                    end else begin
                        q_q        <= up_lat_q ? 3'd0 : mod_lat_q;
                        pass_cnt_q <= 4'd0;
                        if (pass_lat_q == 4'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // stop beats pause, pause beats the count step
                    if (stop) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        abort_q <= 1'b1;
                    end else if (pause) begin
                        state_q <= S_HOLD;
                    end else begin
                        q_q <= q_step_d;
                        if (term_d) begin
                            wrap_q     <= 1'b1;
                            pass_cnt_q <= pass_inc_d;
                        end
                        if (last_d) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (stop) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        abort_q <= 1'b1;
                    end else if (!pause) begin
                        state_q <= S_RUN;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign q        = q_q;
    assign pass_cnt = pass_cnt_q;
    assign busy     = busy_q;
    assign wrap     = wrap_q;
    assign done     = done_q;
    assign abort    = abort_q;
    assign state    = state_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer; each check compares {state,q,pass_cnt,busy,wrap,done,abort}.
module tb_count_sequencer;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] RUN  = 3'd2;
    localparam logic [2:0] HOLD = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic       clk = 1'b0;
    logic       rst, start, stop, pause, up_dn;
    logic [2:0] mod_val, q, state;
    logic [3:0] passes, pass_cnt;
    logic       busy, wrap, done, abort;

    int checks   = 0;
    int errors   = 0;
    int busy_cyc = 0;

    count_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .up_dn(up_dn), .mod_val(mod_val), .passes(passes),
        .q(q), .pass_cnt(pass_cnt), .busy(busy), .wrap(wrap),
        .done(done), .abort(abort), .state(state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        if (busy) busy_cyc++;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b required=%b", tag, obs, exp);
        end
    endtask

    task automatic exp_o(input string tag, input logic [2:0] st, input logic [2:0] eq,
                         input logic [3:0] pc, input logic b, input logic w,
                         input logic d, input logic a);
        chk(tag, {2'b00, state, q, pass_cnt, busy, wrap, done, abort},
                 {2'b00, st, eq, pc, b, w, d, a});
    endtask

    task automatic launch(input logic up, input logic [2:0] m, input logic [3:0] p);
        up_dn   = up;
        mod_val = m;
        passes  = p;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        up_dn = 1'b0; mod_val = 3'd0; passes = 4'd0;
        step();
        step();
        exp_o("reset", IDLE, 3'd0, 4'd0, 0, 0, 0, 0);
        rst = 1'b0;
        step();
        exp_o("idle_hold", IDLE, 3'd0, 4'd0, 0, 0, 0, 0);

        // Up, mod 5, 2 passes; inputs changed and start re-asserted after latching
        busy_cyc = 0;
        launch(1'b1, 3'd5, 4'd2);
        exp_o("t1_load", LOAD, 3'd0, 4'd0, 1, 0, 0, 0);
        up_dn = 1'b0; mod_val = 3'd2; passes = 4'd1;
        step();
        for (int i = 0; i < 12; i++) begin
            if (i == 2) start = 1'b1;
            if (i == 5) start = 1'b0;
            exp_o($sformatf("t1_run%0d", i), RUN, 3'(i % 6), 4'(i / 6), 1, (i == 6), 0, 0);
            step();
        end
        exp_o("t1_done", DONE, 3'd0, 4'd2, 1, 1, 1, 0);
        step();
        exp_o("t1_idle", IDLE, 3'd0, 4'd2, 0, 0, 0, 0);
        chk("t1_busy_cycles", 16'(busy_cyc), 16'd14);

        // Down, mod 3, 1 pass
        launch(1'b0, 3'd3, 4'd1);
        exp_o("t2_load", LOAD, 3'd0, 4'd2, 1, 0, 0, 0);
        step(); exp_o("t2_run3", RUN, 3'd3, 4'd0, 1, 0, 0, 0);
        step(); exp_o("t2_run2", RUN, 3'd2, 4'd0, 1, 0, 0, 0);
        step(); exp_o("t2_run1", RUN, 3'd1, 4'd0, 1, 0, 0, 0);
        step(); exp_o("t2_run0", RUN, 3'd0, 4'd0, 1, 0, 0, 0);
        step(); exp_o("t2_done", DONE, 3'd3, 4'd1, 1, 1, 1, 0);
        step(); exp_o("t2_idle", IDLE, 3'd3, 4'd1, 0, 0, 0, 0);
        step(); exp_o("t2_idle2", IDLE, 3'd3, 4'd1, 0, 0, 0, 0);

        // Up, mod 7, 1 pass, pause at q=4 for three cycles
        launch(1'b1, 3'd7, 4'd1);
        exp_o("t3_load", LOAD, 3'd3, 4'd1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            exp_o($sformatf("t3_run%0d", i), RUN, 3'(i), 4'd0, 1, 0, 0, 0);
        end
        pause = 1'b1;
        step(); exp_o("t3_hold1", HOLD, 3'd4, 4'd0, 1, 0, 0, 0);
        step(); exp_o("t3_hold2", HOLD, 3'd4, 4'd0, 1, 0, 0, 0);
        step(); exp_o("t3_hold3", HOLD, 3'd4, 4'd0, 1, 0, 0, 0);
        pause = 1'b0;
        step(); exp_o("t3_resume", RUN, 3'd4, 4'd0, 1, 0, 0, 0);
        step(); exp_o("t3_run5", RUN, 3'd5, 4'd0, 1, 0, 0, 0);
        step(); exp_o("t3_run6", RUN, 3'd6, 4'd0, 1, 0, 0, 0);
        step(); exp_o("t3_run7", RUN, 3'd7, 4'd0, 1, 0, 0, 0);
        step(); exp_o("t3_done", DONE, 3'd0, 4'd1, 1, 1, 1, 0);
        step(); exp_o("t3_idle", IDLE, 3'd0, 4'd1, 0, 0, 0, 0);

        // Stop together with pause at q=2
        launch(1'b1, 3'd5, 4'd3);
        exp_o("t4_load", LOAD, 3'd0, 4'd1, 1, 0, 0, 0);
        step(); exp_o("t4_run0", RUN, 3'd0, 4'd0, 1, 0, 0, 0);
        step(); exp_o("t4_run1", RUN, 3'd1, 4'd0, 1, 0, 0, 0);
        step(); exp_o("t4_run2", RUN, 3'd2, 4'd0, 1, 0, 0, 0);
        stop = 1'b1; pause = 1'b1;
        step(); exp_o("t4_abort", IDLE, 3'd2, 4'd0, 0, 0, 0, 1);
        stop = 1'b0; pause = 1'b0;
        step(); exp_o("t4_idle", IDLE, 3'd2, 4'd0, 0, 0, 0, 0);

        // Stop during LOAD leaves q and pass_cnt untouched
        launch(1'b1, 3'd4, 4'd2);
        exp_o("t5_load", LOAD, 3'd2, 4'd0, 1, 0, 0, 0);
        stop = 1'b1;
        step(); exp_o("t5_abort", IDLE, 3'd2, 4'd0, 0, 0, 0, 1);
        stop = 1'b0;

        // Zero passes: LOAD straight to DONE, no wrap
        launch(1'b0, 3'd6, 4'd0);
        exp_o("t6_load", LOAD, 3'd2, 4'd0, 1, 0, 0, 0);
        step(); exp_o("t6_done", DONE, 3'd6, 4'd0, 1, 0, 1, 0);
        step(); exp_o("t6_idle", IDLE, 3'd6, 4'd0, 0, 0, 0, 0);

        // mod 0: every step is terminal
        launch(1'b1, 3'd0, 4'd3);
        exp_o("t7_load", LOAD, 3'd6, 4'd0, 1, 0, 0, 0);
        step(); exp_o("t7_run0", RUN, 3'd0, 4'd0, 1, 0, 0, 0);
        step(); exp_o("t7_wrap1", RUN, 3'd0, 4'd1, 1, 1, 0, 0);
        step(); exp_o("t7_wrap2", RUN, 3'd0, 4'd2, 1, 1, 0, 0);
        step(); exp_o("t7_done", DONE, 3'd0, 4'd3, 1, 1, 1, 0);
        step(); exp_o("t7_idle", IDLE, 3'd0, 4'd3, 0, 0, 0, 0);

        // Start and parameter changes in RUN ignored, then reset mid-job
        launch(1'b1, 3'd7, 4'd2);
        exp_o("t8_load", LOAD, 3'd0, 4'd3, 1, 0, 0, 0);
        step(); exp_o("t8_run0", RUN, 3'd0, 4'd0, 1, 0, 0, 0);
        start = 1'b1; up_dn = 1'b0; mod_val = 3'd1; passes = 4'd1;
        step(); exp_o("t8_run1", RUN, 3'd1, 4'd0, 1, 0, 0, 0);
        step(); exp_o("t8_run2", RUN, 3'd2, 4'd0, 1, 0, 0, 0);
        step(); exp_o("t8_run3", RUN, 3'd3, 4'd0, 1, 0, 0, 0);
        rst = 1'b1; stop = 1'b1; pause = 1'b1;
        step(); exp_o("t8_reset", IDLE, 3'd0, 4'd0, 0, 0, 0, 0);
        rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        step(); exp_o("t8_post_reset", IDLE, 3'd0, 4'd0, 0, 0, 0, 0);

        // Fresh job after reset
        launch(1'b0, 3'd2, 4'd1);
        exp_o("t9_load", LOAD, 3'd0, 4'd0, 1, 0, 0, 0);
        step(); exp_o("t9_run2", RUN, 3'd2, 4'd0, 1, 0, 0, 0);
        step(); exp_o("t9_run1", RUN, 3'd1, 4'd0, 1, 0, 0, 0);
        step(); exp_o("t9_run0", RUN, 3'd0, 4'd0, 1, 0, 0, 0);
        step(); exp_o("t9_done", DONE, 3'd2, 4'd1, 1, 1, 1, 0);
        step(); exp_o("t9_idle", IDLE, 3'd2, 4'd1, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 clk  input  1  single clock; all state SHALL update on posedge clk only.
REQ-002 rst  input  1  reset, synchronous and active-high; sampled on posedge clk.
REQ-003 start  input  1  begin a counting job; sampled only in IDLE.
REQ-004 stop  input  1  abort the current job; effective in LOAD, RUN and HOLD.
REQ-005 pause  input  1  level; freezes counting while high in RUN or HOLD.
REQ-006 up_dn  input  1  1 = up count, 0 = down count; latched at start.
REQ-007 mod_val  input  3  terminal value 0..7; latched at start as mod_lat.
REQ-008 passes  input  4  number of full wraps per job; latched at start as pass_lat.
REQ-009 q  output  3  counter value.
REQ-010 pass_cnt  output  4  completed wraps in the current job.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 wrap  output  1  one-cycle pulse on each terminal-count step.
REQ-013 done  output  1  one-cycle pulse; the job completed normally.
REQ-014 abort  output  1  one-cycle pulse; the job was ended by stop.
REQ-015 state  output  3  encoding: IDLE=0, LOAD=1, RUN=2, HOLD=3, DONE=4.

Function
REQ-016 All outputs SHALL be registered; done, wrap and abort SHALL be high for exactly one clock.
REQ-017 IDLE: when start=1, the block SHALL latch up_dn, mod_val and passes and go to LOAD next cycle; while start=0 it SHALL hold q and pass_cnt.
REQ-018 LOAD (one cycle): the block SHALL set q to 0 (up) or mod_lat (down) and clear pass_cnt.
REQ-019 LOAD exit: if pass_lat=0 the block SHALL go to DONE; otherwise it SHALL go to RUN.
REQ-020 RUN with pause=0 and stop=0: q SHALL change by exactly 1 per clock (modulo 8 arithmetic).
REQ-021 Up-mode terminal: when q==mod_lat, the next step SHALL set q to 0, pulse wrap and increment pass_cnt.
REQ-022 Down-mode terminal: when q==0, the next step SHALL set q to mod_lat, pulse wrap and increment pass_cnt.
REQ-023 mod_lat=0: every RUN step SHALL be a terminal step; q SHALL stay 0 and wrap SHALL pulse every cycle.
REQ-024 Job end: on the terminal step where pass_cnt+1 == pass_lat, the block SHALL apply that step, then go to DONE.
REQ-025 DONE (one cycle): done SHALL pulse; then the block SHALL go to IDLE; q and pass_cnt SHALL hold their final values.
REQ-026 RUN with pause=1: the block SHALL go to HOLD without stepping q in that cycle.
REQ-027 HOLD: q and pass_cnt SHALL freeze; when pause=0 the block SHALL return to RUN, with stepping resuming on the following cycle.
REQ-028 stop in LOAD, RUN or HOLD: the block SHALL go to IDLE next cycle, pulse abort, and leave q and pass_cnt frozen with no step.
REQ-029 Priority: stop SHALL win over pause, and pause SHALL win over the count step.
REQ-030 start outside IDLE SHALL be ignored; mod_val, passes and up_dn changes after latching SHALL have no effect.
REQ-031 An illegal state encoding SHALL return the block to IDLE on the next clock.

Reset
REQ-032 rst=1 at posedge clk SHALL force state=IDLE and q, pass_cnt, busy, wrap, done and abort all to 0, and clear the latched job parameters.
REQ-033 rst SHALL override start, stop and pause, including when asserted mid-job; the first non-reset cycle SHALL be IDLE.

Verification
REQ-034 Up, mod_val=5, passes=2, start pulse -> LOAD; q sequence 0,1,2,3,4,5,0,1,2,3,4,5,0; wrap pulses twice; pass_cnt=2; done one cycle; 14 busy cycles.
REQ-035 Down, mod_val=3, passes=1 -> q sequence 3,2,1,0,3; one wrap; done; then IDLE with q=3 and pass_cnt=1.
REQ-036 Up, mod_val=7, passes=1, pause high for 3 cycles at q=4 -> q holds 4 for 3 cycles in HOLD, then resumes 5,6,7,0; done follows.
REQ-037 stop while q=2 in RUN (stop and pause both high) -> abort pulse, state IDLE next cycle, q=2, no done.
REQ-038 passes=0 -> IDLE, LOAD, DONE, IDLE; no wrap pulse; mod_val=0 and passes=3 -> wrap on 3 consecutive cycles, q=0, then done.
REQ-039 rst asserted in RUN and a new start during RUN -> reset clears all outputs in 1 cycle; start in RUN is ignored and the latched parameters are unchanged.
